// File: rtl/rmt_axis_pkg.sv
// Shared definitions for the AXI-Stream receive monitor: stream widths,
// backpressure mode encodings, error flag bit positions and the LFSR used
// for random backpressure.
package rmt_axis_pkg;

  localparam int DATA_W  = 512;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int TUSER_W = 128;
  localparam int CNT_W   = 32;
  localparam int HDR_W   = 128;

  // Backpressure modes
  localparam logic [1:0] BP_ALWAYS    = 2'b00;
  localparam logic [1:0] BP_ALTERNATE = 2'b01;
  localparam logic [1:0] BP_LFSR      = 2'b10;
  localparam logic [1:0] BP_NEVER     = 2'b11;

  // Sticky error flag bit positions
  localparam int ERR_W            = 4;
  localparam int ERR_KEEP_GAP     = 0;
  localparam int ERR_KEEP_SHORT   = 1;
  localparam int ERR_STALL_CHANGE = 2;
  localparam int ERR_KEEP_ZERO    = 3;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback is the
  // XOR of bits 0,2,3,5 and enters at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/rmt_bp_gen.sv
// Backpressure generator: turns bp_mode into a registered tready. The value
// chosen in cycle N is presented in cycle N+1; the LFSR free-runs in every mode.
module rmt_bp_gen
  import rmt_axis_pkg::*;
(
  input  logic       clk,
  input  logic       aresetn,
  input  logic [1:0] bp_mode,
  output logic       tready
);

  logic [15:0] lfsr;
  logic        toggle;
  logic        ready_d;

  // Select the next tready from the current mode and pattern state
  always_comb begin
    ready_d = 1'b0;
    case (bp_mode)
      BP_ALWAYS:    ready_d = 1'b1;
      BP_ALTERNATE: ready_d = toggle;
      BP_LFSR:      ready_d = lfsr[0];
      BP_NEVER:     ready_d = 1'b0;
      default:      ready_d = 1'b0;
    endcase
  end

  // Pattern state and registered tready
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr   <= LFSR_SEED;
      toggle <= 1'b0;
      tready <= 1'b0;
    end else begin
      lfsr   <= lfsr_next(lfsr);
      toggle <= ~toggle;
      tready <= ready_d;
    end
  end

endmodule

// File: rtl/rmt_axis_rx_monitor.sv
// Receive-side AXI-Stream monitor: accepts packets under programmable
// backpressure, keeps wrap-around packet/beat/byte statistics, flags
// protocol violations and captures header/tuser of the last packet.
module rmt_axis_rx_monitor
  import rmt_axis_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DATA_W,
  parameter int C_S_AXIS_TUSER_WIDTH = TUSER_W,
  parameter int CNT_WIDTH            = CNT_W,
  parameter int HDR_WIDTH            = HDR_W
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic [1:0]                        bp_mode,
  input  logic                              clr_stats,
  output logic [CNT_WIDTH-1:0]              pkt_cnt,
  output logic [CNT_WIDTH-1:0]              beat_cnt,
  output logic [CNT_WIDTH-1:0]              byte_cnt,
  output logic [CNT_WIDTH-1:0]              err_cnt,
  output logic [ERR_W-1:0]                  err_flags,
  output logic [HDR_WIDTH-1:0]              last_hdr,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   last_tuser,
  output logic                              pkt_done
);

  localparam int KW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PC_W = $clog2(KW + 1);

  function automatic logic [PC_W-1:0] popcount(input logic [KW-1:0] k);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < KW; i++) n = n + PC_W'(k[i]);
    return n;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  rmt_bp_gen u_bp_gen (
    .clk     (clk),
    .aresetn (aresetn),
    .bp_mode (bp_mode),
    .tready  (s_axis_tready)
  );

  rx_state_t                       state_q, state_d;
  logic                            load_shadow, load_direct, load_from_shadow;
  logic                            accept;
  logic [HDR_WIDTH-1:0]            hdr_in;
  logic [HDR_WIDTH-1:0]            shadow_hdr;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] shadow_tuser;

  // Previous-cycle stream snapshot for the stall-stability check
  logic                            stall_p1;
  logic [C_S_AXIS_DATA_WIDTH-1:0]  tdata_p1;
  logic [KW-1:0]                   tkeep_p1;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_p1;
  logic                            tlast_p1;

  logic [ERR_W-1:0]                err_vec;

  assign accept = s_axis_tvalid & s_axis_tready;
  assign hdr_in = s_axis_tdata[C_S_AXIS_DATA_WIDTH-1 -: HDR_WIDTH];

  // Packet framing FSM: decides where the completed packet's capture comes from
  always_comb begin
    state_d          = state_q;
    load_shadow      = 1'b0;
    load_direct      = 1'b0;
    load_from_shadow = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (s_axis_tlast) begin
            load_direct = 1'b1;
          end else begin
            load_shadow = 1'b1;
            state_d     = ST_IN_PKT;
          end
        end
      end
      ST_IN_PKT: begin
        if (accept && s_axis_tlast) begin
          load_from_shadow = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register; clr_stats deliberately leaves framing intact
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Shadow capture of the first beat of a multi-beat packet
  always_ff @(posedge clk) begin
    if (load_shadow) begin
      shadow_hdr   <= hdr_in;
      shadow_tuser <= s_axis_tuser;
    end
  end

  // Stall tracking: remember whether the source was held off and what it showed
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) stall_p1 <= 1'b0;
    else          stall_p1 <= s_axis_tvalid & ~s_axis_tready;
  end

  // Stream snapshot registers (data only, no reset needed)
  always_ff @(posedge clk) begin
    tdata_p1 <= s_axis_tdata;
    tkeep_p1 <= s_axis_tkeep;
    tuser_p1 <= s_axis_tuser;
    tlast_p1 <= s_axis_tlast;
  end

  // Per-cycle violation vector; beat checks only on accepted beats
  always_comb begin
    err_vec = '0;
    err_vec[ERR_KEEP_GAP]   = accept &&
                              ((s_axis_tkeep & (s_axis_tkeep + KW'(1))) != '0);
    err_vec[ERR_KEEP_SHORT] = accept && !s_axis_tlast && (s_axis_tkeep != '1);
    err_vec[ERR_KEEP_ZERO]  = accept && (s_axis_tkeep == '0);
    err_vec[ERR_STALL_CHANGE] = stall_p1 &&
                                (!s_axis_tvalid ||
                                 (s_axis_tdata != tdata_p1) ||
                                 (s_axis_tkeep != tkeep_p1) ||
                                 (s_axis_tuser != tuser_p1) ||
                                 (s_axis_tlast != tlast_p1));
  end

  // Statistics, sticky flags and captures; clr_stats overrides this cycle's beat
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt    <= '0;
      beat_cnt   <= '0;
      byte_cnt   <= '0;
      err_cnt    <= '0;
      err_flags  <= '0;
      last_hdr   <= '0;
      last_tuser <= '0;
      pkt_done   <= 1'b0;
    end else if (clr_stats) begin
      pkt_cnt    <= '0;
      beat_cnt   <= '0;
      byte_cnt   <= '0;
      err_cnt    <= '0;
      err_flags  <= '0;
      last_hdr   <= '0;
      last_tuser <= '0;
      pkt_done   <= 1'b0;
    end else begin
      pkt_done <= accept & s_axis_tlast;
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
        byte_cnt <= byte_cnt + CNT_WIDTH'(popcount(s_axis_tkeep));
        if (s_axis_tlast) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      err_flags <= err_flags | err_vec;
      if (|err_vec) err_cnt <= sat_inc(err_cnt);
      if (load_direct) begin
        last_hdr   <= hdr_in;
        last_tuser <= s_axis_tuser;
      end else if (load_from_shadow) begin
        last_hdr   <= shadow_hdr;
        last_tuser <= shadow_tuser;
      end
    end
  end

endmodule

// File: tb/tb_rmt_axis_rx_monitor.sv
// Directed testbench for rmt_axis_rx_monitor with hand-computed expectations.
module tb_rmt_axis_rx_monitor;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic [127:0] tuser;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic [1:0]   bp_mode;
  logic         clr_stats;
  logic [31:0]  pkt_cnt, beat_cnt, byte_cnt, err_cnt;
  logic [3:0]   err_flags;
  logic [127:0] last_hdr, last_tuser;
  logic         pkt_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rmt_axis_rx_monitor dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .bp_mode       (bp_mode),
    .clr_stats     (clr_stats),
    .pkt_cnt       (pkt_cnt),
    .beat_cnt      (beat_cnt),
    .byte_cnt      (byte_cnt),
    .err_cnt       (err_cnt),
    .err_flags     (err_flags),
    .last_hdr      (last_hdr),
    .last_tuser    (last_tuser),
    .pkt_done      (pkt_done)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input logic [127:0] u, input logic l);
    logic acc;
    int   n;
    tdata = d; tkeep = k; tuser = u; tlast = l; tvalid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk); #1;
      n++;
    end
    tvalid = 1'b0;
    if (!acc) chk("accept_timeout", 128'(acc), 128'd1);
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
  endtask

  logic [511:0] d;
  logic [127:0] u0;
  int           rdy_seen;

  initial begin
    aresetn = 1'b0; tdata = '0; tkeep = '0; tuser = '0; tvalid = 1'b0;
    tlast = 1'b0; bp_mode = 2'b00; clr_stats = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_tready", 128'(tready), 128'd0);
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("rst_err_flags", 128'(err_flags), 128'd0);
    chk("rst_last_hdr", last_hdr, 128'd0);
    chk("rst_pkt_done", 128'(pkt_done), 128'd0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;

    // 1: mode 00, 4-beat packet
    u0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    send_beat({{2{64'hffffffffffffffff}}, 384'b0}, '1, u0, 1'b0);
    for (int b = 1; b < 4; b++) send_beat(512'(b), '1, 128'(b), b == 3);
    chk("t1_pkt_cnt", 128'(pkt_cnt), 128'd1);
    chk("t1_beat_cnt", 128'(beat_cnt), 128'd4);
    chk("t1_byte_cnt", 128'(byte_cnt), 128'd256);
    chk("t1_last_hdr", last_hdr, {128{1'b1}});
    chk("t1_last_tuser", last_tuser, u0);
    chk("t1_err_flags", 128'(err_flags), 128'd0);
    chk("t1_pkt_done_hi", 128'(pkt_done), 128'd1);
    @(posedge clk); #1;
    chk("t1_pkt_done_lo", 128'(pkt_done), 128'd0);

    // 2: single-beat packet, 8 bytes
    send_beat({128'hcafe, 384'h5}, 64'h00000000000000ff, 128'h42, 1'b1);
    chk("t2_pkt_cnt", 128'(pkt_cnt), 128'd2);
    chk("t2_byte_cnt", 128'(byte_cnt), 128'd264);
    chk("t2_last_hdr", last_hdr, 128'hcafe);
    chk("t2_err_flags", 128'(err_flags), 128'd0);

    // 3: mode 11 holds everything, then mode 00 accepts two cycles after the switch
    bp_mode = 2'b11;
    @(posedge clk); #1;
    tdata = 512'h33; tkeep = '1; tuser = 128'h33; tlast = 1'b1; tvalid = 1'b1;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (tready) rdy_seen++;
    end
    chk("t3_ready_seen", 128'(rdy_seen), 128'd0);
    chk("t3_beat_hold", 128'(beat_cnt), 128'd5);
    @(posedge clk); #1;
    bp_mode = 2'b00;
    @(posedge clk); #1;
    chk("t3_beat_plus1", 128'(beat_cnt), 128'd5);
    chk("t3_tready_up", 128'(tready), 128'd1);
    @(posedge clk); #1;
    tvalid = 1'b0;
    chk("t3_beat_plus2", 128'(beat_cnt), 128'd6);
    chk("t3_pkt_cnt", 128'(pkt_cnt), 128'd3);
    chk("t3_err_cnt", 128'(err_cnt), 128'd0);

    // 4: mode 01, change data while stalled
    bp_mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!tready) break;
    end
    chk("t4_found_stall", 128'(tready), 128'd0);
    tdata = 512'hA; tkeep = '1; tuser = 128'hA; tlast = 1'b1; tvalid = 1'b1;
    @(posedge clk); #1;
    tdata = 512'hB;
    @(posedge clk); #1;
    tvalid = 1'b0;
    chk("t4_err_flags", 128'(err_flags), 128'h4);
    chk("t4_err_cnt", 128'(err_cnt), 128'd1);
    chk("t4_pkt_cnt", 128'(pkt_cnt), 128'd4);
    pulse_clr();
    chk("t4_clr_pkt", 128'(pkt_cnt), 128'd0);
    chk("t4_clr_beat", 128'(beat_cnt), 128'd0);
    chk("t4_clr_byte", 128'(byte_cnt), 128'd0);
    chk("t4_clr_err_cnt", 128'(err_cnt), 128'd0);
    chk("t4_clr_flags", 128'(err_flags), 128'd0);
    chk("t4_clr_hdr", last_hdr, 128'd0);
    chk("t4_clr_tuser", last_tuser, 128'd0);

    // 5: tkeep violations
    bp_mode = 2'b00;
    send_beat(512'h1, 64'h0f0f, 128'h1, 1'b1);
    chk("t5_gap_flags", 128'(err_flags), 128'h1);
    chk("t5_gap_cnt", 128'(err_cnt), 128'd1);
    send_beat(512'h2, 64'h00ff, 128'h2, 1'b0);
    chk("t5_short_flags", 128'(err_flags), 128'h3);
    send_beat(512'h3, 64'h0, 128'h3, 1'b1);
    chk("t5_zero_flags", 128'(err_flags), 128'hB);
    chk("t5_err_cnt", 128'(err_cnt), 128'd3);
    chk("t5_byte_cnt", 128'(byte_cnt), 128'd16);
    chk("t5_pkt_cnt", 128'(pkt_cnt), 128'd2);
    pulse_clr();

    // 6: mode 10, 100 four-beat packets
    bp_mode = 2'b10;
    for (int p = 0; p < 100; p++) begin
      for (int b = 0; b < 4; b++) begin
        d = '0; d[511:480] = 32'(p); d[7:0] = 8'(b);
        send_beat(d, '1, 128'(p * 4 + b), b == 3);
      end
    end
    chk("t6_pkt_cnt", 128'(pkt_cnt), 128'd100);
    chk("t6_beat_cnt", 128'(beat_cnt), 128'd400);
    chk("t6_byte_cnt", 128'(byte_cnt), 128'd25600);
    chk("t6_err_cnt", 128'(err_cnt), 128'd0);
    chk("t6_last_hdr", last_hdr, {32'd99, 96'd0});
    chk("t6_last_tuser", last_tuser, 128'd396);

    // Reset mid-packet
    bp_mode = 2'b00;
    d = '0; d[511:384] = 128'hdead;
    send_beat(d, '1, 128'h51, 1'b0);
    send_beat(512'h52, '1, 128'h52, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("r_tready", 128'(tready), 128'd0);
    chk("r_pkt_cnt", 128'(pkt_cnt), 128'd0);
    chk("r_beat_cnt", 128'(beat_cnt), 128'd0);
    chk("r_byte_cnt", 128'(byte_cnt), 128'd0);
    chk("r_err_cnt", 128'(err_cnt), 128'd0);
    chk("r_err_flags", 128'(err_flags), 128'd0);
    chk("r_last_hdr", last_hdr, 128'd0);
    chk("r_last_tuser", last_tuser, 128'd0);
    chk("r_pkt_done", 128'(pkt_done), 128'd0);
    repeat (2) @(posedge clk); #1;
    chk("r_tready_hold", 128'(tready), 128'd0);
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    d = '0; d[511:384] = 128'hbeef_0001;
    send_beat(d, '1, 128'h77, 1'b0);
    send_beat(512'h54, '1, 128'h54, 1'b1);
    chk("r_new_pkt_cnt", 128'(pkt_cnt), 128'd1);
    chk("r_new_beat_cnt", 128'(beat_cnt), 128'd2);
    chk("r_new_hdr", last_hdr, 128'hbeef_0001);
    chk("r_new_tuser", last_tuser, 128'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
